// File: rtl/regfile_param.sv
// Parametrised 1-write/2-read register file with optional hardwired-zero r0,
// write-to-read bypass, registered reads and a one-register-per-cycle clear engine.
module regfile_param #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1,
  parameter bit          READ_REG = 1'b0
) (
  input  logic              clock,
  input  logic              ctrl_reset,
  input  logic              ctrl_writeEnable,
  input  logic [ADDR_W-1:0] ctrl_writeReg,
  input  logic [DATA_W-1:0] data_writeReg,
  input  logic [ADDR_W-1:0] ctrl_readRegA,
  input  logic [ADDR_W-1:0] ctrl_readRegB,
  input  logic              ctrl_clear,
  output logic [DATA_W-1:0] data_readRegA,
  output logic [DATA_W-1:0] data_readRegB,
  output logic              status_busy,
  output logic              status_writeDropped
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  localparam logic [ADDR_W-1:0] PTR_FIRST = ZERO_REG ? ADDR_W'(1) : ADDR_W'(0);
  localparam logic [ADDR_W-1:0] PTR_LAST  = ADDR_W'(DEPTH - 1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [0:0]        r_state;
  logic [0:0]        w_state_nxt;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W-1:0] w_ptr_nxt;
  logic              r_dropped;
  logic              w_busy;
  logic              w_wr_acc;
  logic              w_wr_en;
  logic [DATA_W-1:0] w_rd_a;
  logic [DATA_W-1:0] w_rd_b;

  assign w_busy   = (r_state == ST_CLEAR);
  assign w_wr_acc = ctrl_writeEnable && !w_busy && !ctrl_reset;
  // An accepted write to a hardwired r0 is swallowed, so it never bypasses either.
  assign w_wr_en  = w_wr_acc && !(ZERO_REG && (ctrl_writeReg == '0));

  // Clear engine state register
  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  // Clear engine next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      ST_IDLE: begin
        if (ctrl_clear) begin
          w_state_nxt = ST_CLEAR;
          w_ptr_nxt   = PTR_FIRST;
        end
      end
      ST_CLEAR: begin
        w_ptr_nxt = r_ptr + ADDR_W'(1);
        if (r_ptr == PTR_LAST) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Storage: writes are blocked while sweeping, so the two updates never collide
  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      r_mem <= '{default: '0};
    end else begin
      if (w_wr_en) begin
        r_mem[ctrl_writeReg] <= data_writeReg;
      end
      if (w_busy) begin
        r_mem[r_ptr] <= '0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      r_dropped <= 1'b0;
    end else begin
      r_dropped <= ctrl_writeEnable && w_busy;
    end
  end

  always_comb begin
    w_rd_a = r_mem[ctrl_readRegA];
    if (BYPASS && w_wr_en && (ctrl_readRegA == ctrl_writeReg)) begin
      w_rd_a = data_writeReg;
    end
    if (ZERO_REG && (ctrl_readRegA == '0)) begin
      w_rd_a = '0;
    end
  end

  always_comb begin
    w_rd_b = r_mem[ctrl_readRegB];
    if (BYPASS && w_wr_en && (ctrl_readRegB == ctrl_writeReg)) begin
      w_rd_b = data_writeReg;
    end
    if (ZERO_REG && (ctrl_readRegB == '0)) begin
      w_rd_b = '0;
    end
  end

  generate
    if (READ_REG) begin : g_rd_reg
      logic [DATA_W-1:0] r_rd_a;
      logic [DATA_W-1:0] r_rd_b;

      always_ff @(posedge clock) begin
        if (ctrl_reset) begin
          r_rd_a <= '0;
          r_rd_b <= '0;
        end else begin
          r_rd_a <= w_rd_a;
          r_rd_b <= w_rd_b;
        end
      end

      assign data_readRegA = r_rd_a;
      assign data_readRegB = r_rd_b;
    end else begin : g_rd_comb
      assign data_readRegA = w_rd_a;
      assign data_readRegB = w_rd_b;
    end
  endgenerate

  assign status_busy         = w_busy;
  assign status_writeDropped = r_dropped;

endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench: three configurations of regfile_param driven in lockstep
// and compared every cycle against an array-based reference model.
module tb_regfile_param;

  logic        clk;
  logic        rst;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic [4:0]  ra;
  logic [4:0]  rb;
  logic        clr;

  logic [31:0] a0, b0, a1, b1;
  logic [15:0] a2, b2;
  logic        busy0, drop0, busy1, drop1, busy2, drop2;

  // Default configuration
  regfile_param u_def (
    .clock(clk), .ctrl_reset(rst), .ctrl_writeEnable(we), .ctrl_writeReg(wa),
    .data_writeReg(wd), .ctrl_readRegA(ra), .ctrl_readRegB(rb), .ctrl_clear(clr),
    .data_readRegA(a0), .data_readRegB(b0), .status_busy(busy0),
    .status_writeDropped(drop0)
  );

  // No bypass
  regfile_param #(.BYPASS(1'b0)) u_nobyp (
    .clock(clk), .ctrl_reset(rst), .ctrl_writeEnable(we), .ctrl_writeReg(wa),
    .data_writeReg(wd), .ctrl_readRegA(ra), .ctrl_readRegB(rb), .ctrl_clear(clr),
    .data_readRegA(a1), .data_readRegB(b1), .status_busy(busy1),
    .status_writeDropped(drop1)
  );

  // Small, ordinary r0, registered reads
  regfile_param #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1'b0), .BYPASS(1'b1), .READ_REG(1'b1)) u_small (
    .clock(clk), .ctrl_reset(rst), .ctrl_writeEnable(we), .ctrl_writeReg(wa[2:0]),
    .data_writeReg(wd[15:0]), .ctrl_readRegA(ra[2:0]), .ctrl_readRegB(rb[2:0]), .ctrl_clear(clr),
    .data_readRegA(a2), .data_readRegB(b2), .status_busy(busy2),
    .status_writeDropped(drop2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  logic [31:0] m0 [32];
  int          left0, idx0;
  logic        mdrop0;
  logic [15:0] m2 [8];
  int          left2, idx2;
  logic        mdrop2;
  logic [15:0] q_a2, q_b2;
  bit          chk_en = 1'b0;

  // Last sampled outputs for directed checks
  logic [31:0] s_a0, s_b0, s_a1;
  logic [15:0] s_a2;
  logic        s_busy0, s_drop0, s_busy2;

  function automatic logic [31:0] exp_big(input logic [4:0] addr, input logic acc,
                                          input bit byp);
    if (addr == 5'd0) return 32'h0;
    if (byp && acc && addr == wa) return wd;
    return m0[addr];
  endfunction

  function automatic logic [15:0] exp_small(input logic [2:0] addr, input logic acc);
    if (acc && addr == wa[2:0]) return wd[15:0];
    return m2[addr];
  endfunction

  task automatic cycle(input logic i_we, input logic [4:0] i_wa, input logic [31:0] i_wd,
                       input logic [4:0] i_ra, input logic [4:0] i_rb,
                       input logic i_clr, input logic i_rst);
    logic        bz0, bz2, acc0, acc2;
    logic [15:0] c_a2, c_b2;
    @(negedge clk);
    we = i_we; wa = i_wa; wd = i_wd; ra = i_ra; rb = i_rb; clr = i_clr; rst = i_rst;
    #1;
    bz0  = (left0 != 0);
    bz2  = (left2 != 0);
    acc0 = we && !bz0 && !rst;
    acc2 = we && !bz2 && !rst;
    c_a2 = exp_small(ra[2:0], acc2);
    c_b2 = exp_small(rb[2:0], acc2);
    if (chk_en) begin
      chk("rdA_byp",   a0, exp_big(ra, acc0, 1'b1));
      chk("rdB_byp",   b0, exp_big(rb, acc0, 1'b1));
      chk("rdA_nobyp", a1, exp_big(ra, acc0, 1'b0));
      chk("rdB_nobyp", b1, exp_big(rb, acc0, 1'b0));
      chk("busy",      32'(busy0), 32'(bz0));
      chk("busy_nb",   32'(busy1), 32'(bz0));
      chk("dropped",   32'(drop0), 32'(mdrop0));
      chk("drop_nb",   32'(drop1), 32'(mdrop0));
      chk("rdA_rr",    32'(a2), 32'(q_a2));
      chk("rdB_rr",    32'(b2), 32'(q_b2));
      chk("busy_rr",   32'(busy2), 32'(bz2));
      chk("drop_rr",   32'(drop2), 32'(mdrop2));
    end
    s_a0 = a0; s_b0 = b0; s_a1 = a1; s_a2 = a2;
    s_busy0 = busy0; s_drop0 = drop0; s_busy2 = busy2;
    @(posedge clk);
    if (rst) begin
      m0 = '{default: '0}; m2 = '{default: '0};
      left0 = 0; left2 = 0; idx0 = 0; idx2 = 0;
      mdrop0 = 1'b0; mdrop2 = 1'b0; q_a2 = '0; q_b2 = '0;
      chk_en = 1'b1;
    end else begin
      q_a2 = c_a2; q_b2 = c_b2;
      mdrop0 = we && bz0;
      mdrop2 = we && bz2;
      if (acc0 && wa != 5'd0) m0[wa] = wd;
      if (acc2) m2[wa[2:0]] = wd[15:0];
      if (bz0) begin
        m0[idx0] = '0; idx0++; left0--;
      end else if (clr) begin
        left0 = 31; idx0 = 1;
      end
      if (bz2) begin
        m2[idx2] = '0; idx2++; left2--;
      end else if (clr) begin
        left2 = 8; idx2 = 0;
      end
    end
  endtask

  task automatic idle(input logic [4:0] i_ra, input logic [4:0] i_rb);
    cycle(1'b0, 5'd0, 32'h0, i_ra, i_rb, 1'b0, 1'b0);
  endtask

  initial begin
    int bcnt, bcnt2, dcnt;
    we = 1'b0; wa = '0; wd = '0; ra = '0; rb = '0; clr = 1'b0; rst = 1'b1;
    m0 = '{default: '0}; m2 = '{default: '0};
    left0 = 0; left2 = 0; idx0 = 0; idx2 = 0;
    mdrop0 = 1'b0; mdrop2 = 1'b0; q_a2 = '0; q_b2 = '0;

    cycle(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 1'b1);
    cycle(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 1'b1);
    idle(5'd9, 5'd17);
    chk("reset_rdA", s_a0, 32'h0);

    // Basic write/read and hardwired r0
    cycle(1'b1, 5'd5, 32'hDEADBEEF, 5'd1, 5'd0, 1'b0, 1'b0);
    idle(5'd5, 5'd0);
    chk("def_rdA", s_a0, 32'hDEADBEEF);
    chk("def_rdB", s_b0, 32'h0);
    cycle(1'b1, 5'd0, 32'h1234, 5'd3, 5'd3, 1'b0, 1'b0);
    idle(5'd0, 5'd0);
    chk("r0_zero", s_a0, 32'h0);

    // Bypass vs no bypass
    cycle(1'b1, 5'd7, 32'hCAFEF00D, 5'd7, 5'd5, 1'b0, 1'b0);
    chk("byp_same", s_a0, 32'hCAFEF00D);
    chk("nobyp_old", s_a1, 32'h0);
    idle(5'd7, 5'd5);
    chk("nobyp_next", s_a1, 32'hCAFEF00D);

    // Fill r1..r31 with their index, then sweep with a dropped write mid-clear
    for (int i = 1; i < 32; i++) cycle(1'b1, 5'(i), 32'(i), 5'(i), 5'd0, 1'b0, 1'b0);
    cycle(1'b0, 5'd0, 32'h0, 5'd3, 5'd20, 1'b1, 1'b0);
    bcnt = 0; bcnt2 = 0; dcnt = 0;
    for (int i = 0; i < 40; i++) begin
      cycle(i == 5, 5'd10, 32'hAAAA5555, 5'd3, 5'd20, 1'b0, 1'b0);
      if (s_drop0) dcnt++;
      if (s_busy2) bcnt2++;
      if (i == 3) begin
        chk("clr_r3_done", s_a0, 32'h0);
        chk("clr_r20_kept", s_b0, 32'd20);
      end
      if (s_busy0) bcnt++;
      else if (bcnt > 0) break;
    end
    chk("clr_len", 32'(bcnt), 32'd31);
    chk("clr_len_rr", 32'(bcnt2), 32'd8);
    chk("drop_pulses", 32'(dcnt), 32'd1);
    idle(5'd10, 5'd20);
    chk("clr_r10", s_a0, 32'h0);

    // Reset on busy cycle 10
    for (int i = 1; i < 32; i++) cycle(1'b1, 5'(i), 32'(i * 3), 5'd0, 5'd0, 1'b0, 1'b0);
    cycle(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) idle(5'd20, 5'd31);
    cycle(1'b1, 5'd6, 32'h66, 5'd20, 5'd31, 1'b1, 1'b1);
    idle(5'd20, 5'd31);
    chk("rst_busy", 32'(s_busy0), 32'h0);
    chk("rst_rdA", s_a0, 32'h0);
    chk("rst_rdB", s_b0, 32'h0);
    cycle(1'b1, 5'd4, 32'h44, 5'd1, 5'd1, 1'b0, 1'b0);
    idle(5'd4, 5'd0);
    chk("rst_wr_r4", s_a0, 32'h44);

    // Clear and write in the same idle cycle
    cycle(1'b1, 5'd2, 32'h55, 5'd2, 5'd2, 1'b1, 1'b0);
    idle(5'd2, 5'd2);
    chk("conc_busy1", s_a0, 32'h55);
    idle(5'd2, 5'd2);
    idle(5'd2, 5'd2);
    chk("conc_after2", s_a0, 32'h0);
    for (int i = 0; i < 40; i++) begin
      idle(5'd2, 5'd2);
      if (!s_busy0 && !s_busy2) break;
    end
    chk("conc_drain", 32'(s_busy0), 32'h0);

    // Registered reads, ordinary r0
    cycle(1'b1, 5'd0, 32'h0000BEEF, 5'd1, 5'd1, 1'b0, 1'b0);
    idle(5'd0, 5'd0);
    idle(5'd5, 5'd0);
    chk("rr_r0", 32'(s_a2), 32'h0000BEEF);

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      logic        r_we, r_clr, r_rst;
      logic [4:0]  r_wa, r_ra, r_rb;
      logic [31:0] r_wd;
      r_we  = ($urandom_range(0, 1) == 1);
      r_wa  = 5'($urandom);
      r_wd  = $urandom;
      r_ra  = ($urandom_range(0, 3) == 0) ? r_wa : 5'($urandom);
      r_rb  = ($urandom_range(0, 3) == 0) ? r_wa : 5'($urandom);
      r_clr = ($urandom_range(0, 39) == 0);
      r_rst = ($urandom_range(0, 149) == 0);
      cycle(r_we, r_wa, r_wd, r_ra, r_rb, r_clr, r_rst);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
